// File: rtl/junction_arbiter_pkg.sv
// Shared types for the junction arbiter: state encodings (equal to the display codes) and track sides.
package train_pkg;

  localparam logic [3:0] FAULT_CODE = 4'hF;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'h0,
    ST_SETUP_A = 4'h1,
    ST_GRANT_A = 4'h2,
    ST_OCC_A   = 4'h3,
    ST_SETUP_B = 4'h5,
    ST_GRANT_B = 4'h6,
    ST_OCC_B   = 4'h7,
    ST_FAULT   = FAULT_CODE
  } state_e;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  // The side that gets priority when both trains are waiting.
  function automatic side_e other_side(input side_e s);
    return (s == SIDE_A) ? SIDE_B : SIDE_A;
  endfunction

endpackage

// File: rtl/junction_arbiter_if.sv
// Sensor inputs and driver outputs of the junction arbiter; master = sensor/driver side, slave = arbiter.
interface junction_arbiter_if;
  logic       s_req_a;
  logic       s_req_b;
  logic       s_entry_a;
  logic       s_entry_b;
  logic       s_exit;
  logic       s_estop;
  logic       fault_clr;
  logic       go_a;
  logic       go_b;
  logic       switch_pos;
  logic       busy;
  logic       fault;
  logic [3:0] state_code;

  modport master (
    output s_req_a, s_req_b, s_entry_a, s_entry_b, s_exit, s_estop, fault_clr,
    input  go_a, go_b, switch_pos, busy, fault, state_code
  );

  modport slave (
    input  s_req_a, s_req_b, s_entry_a, s_entry_b, s_exit, s_estop, fault_clr,
    output go_a, go_b, switch_pos, busy, fault, state_code
  );
endinterface

// File: rtl/junction_arbiter_sensor_debounce.sv
// Two-flop synchronizer plus debouncer for one track sensor; outputs the qualified level and a rise pulse.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;
  logic          rise_r;

  // Synchronize, then accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r  <= 2'b00;
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], raw};
      rise_r <= 1'b0;
      if (sync_r[1] == level_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r >= CNT_LAST) begin
        level_r <= sync_r[1];
        rise_r  <= sync_r[1];
        cnt_r   <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/junction_arbiter.sv
// Grants the shared junction to train A or B and sequences switch and go signals.
// Define JUNCTION_TIMEOUT_EN to release a grant that sees no entry within TIMEOUT_CYCLES.
module junction_arbiter
  import train_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SWITCH_SETTLE   = 8,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input logic               clk,
  input logic               rst_n,
  junction_arbiter_if.slave bus
);

  localparam int REQ_A = 0, REQ_B = 1, ENT_A = 2, ENT_B = 3, EXIT = 4, ESTOP = 5;

`ifdef JUNCTION_TIMEOUT_EN
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SWITCH_SETTLE) ? TIMEOUT_CYCLES : SWITCH_SETTLE;
`else
  localparam int CNT_MAX = SWITCH_SETTLE;
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_SAT     = {CW{1'b1}};
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SWITCH_SETTLE - 1);
`ifdef JUNCTION_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  logic [5:0] raw_s;
  logic [5:0] level_s;
  logic [5:0] rise_s;
  logic       unused_bits_s;

  assign raw_s = {bus.s_estop, bus.s_exit, bus.s_entry_b, bus.s_entry_a, bus.s_req_b, bus.s_req_a};
  assign unused_bits_s = ^{rise_s[REQ_A], rise_s[REQ_B], rise_s[ESTOP],
                           level_s[ENT_A], level_s[ENT_B], level_s[EXIT]};

  for (genvar i = 0; i < 6; i++) begin : g_sense
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_s[i]),
      .level (level_s[i]),
      .rise  (rise_s[i])
    );
  end

  state_e        state_r, state_next_s;
  side_e         last_served_r, served_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic          switch_next_s;
  logic          go_a_r, go_b_r, switch_pos_r, busy_r, fault_r;
  logic [3:0]    state_code_r;

  // Next-state logic; a qualified estop overrides every other transition.
  always_comb begin
    state_next_s  = state_r;
    served_next_s = last_served_r;
    if (level_s[ESTOP]) begin
      state_next_s = ST_FAULT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (level_s[REQ_A] && level_s[REQ_B]) begin
            state_next_s = (other_side(last_served_r) == SIDE_A) ? ST_SETUP_A : ST_SETUP_B;
          end else if (level_s[REQ_A]) begin
            state_next_s = ST_SETUP_A;
          end else if (level_s[REQ_B]) begin
            state_next_s = ST_SETUP_B;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_SETUP_A: begin
          if (cnt_r >= SETTLE_LAST) state_next_s = ST_GRANT_A;
          else                      state_next_s = ST_SETUP_A;
        end
        ST_SETUP_B: begin
          if (cnt_r >= SETTLE_LAST) state_next_s = ST_GRANT_B;
          else                      state_next_s = ST_SETUP_B;
        end
        ST_GRANT_A: begin
          if (rise_s[ENT_B]) begin
            state_next_s = ST_FAULT;
          end else if (rise_s[ENT_A]) begin
            state_next_s = ST_OCC_A;
`ifdef JUNCTION_TIMEOUT_EN
          end else if (cnt_r >= TIMEOUT_LAST) begin
            state_next_s  = ST_IDLE;
            served_next_s = SIDE_A;
`endif
          end else begin
            state_next_s = ST_GRANT_A;
          end
        end
        ST_GRANT_B: begin
          if (rise_s[ENT_A]) begin
            state_next_s = ST_FAULT;
          end else if (rise_s[ENT_B]) begin
            state_next_s = ST_OCC_B;
`ifdef JUNCTION_TIMEOUT_EN
          end else if (cnt_r >= TIMEOUT_LAST) begin
            state_next_s  = ST_IDLE;
            served_next_s = SIDE_B;
`endif
          end else begin
            state_next_s = ST_GRANT_B;
          end
        end
        ST_OCC_A: begin
          if (rise_s[EXIT]) begin
            state_next_s  = ST_IDLE;
            served_next_s = SIDE_A;
          end else begin
            state_next_s = ST_OCC_A;
          end
        end
        ST_OCC_B: begin
          if (rise_s[EXIT]) begin
            state_next_s  = ST_IDLE;
            served_next_s = SIDE_B;
          end else begin
            state_next_s = ST_OCC_B;
          end
        end
        ST_FAULT: begin
          if (bus.fault_clr) state_next_s = ST_IDLE;
          else               state_next_s = ST_FAULT;
        end
        default: state_next_s = ST_FAULT;
      endcase
    end
  end

  // Per-state counter restarts on every state change and saturates instead of wrapping.
  always_comb begin
    cnt_next_s = cnt_r;
    if (state_next_s != state_r) begin
      cnt_next_s = CNT_ZERO;
    end else if (cnt_r == CNT_SAT) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  // The switch only moves while a route is being set up; otherwise it keeps its position.
  always_comb begin
    switch_next_s = switch_pos_r;
    if (state_next_s == ST_SETUP_A) begin
      switch_next_s = 1'b0;
    end else if (state_next_s == ST_SETUP_B) begin
      switch_next_s = 1'b1;
    end else begin
      switch_next_s = switch_pos_r;
    end
  end

  // State, counter and outputs all register from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      last_served_r <= SIDE_B;
      cnt_r         <= CNT_ZERO;
      go_a_r        <= 1'b0;
      go_b_r        <= 1'b0;
      switch_pos_r  <= 1'b0;
      busy_r        <= 1'b0;
      fault_r       <= 1'b0;
      state_code_r  <= 4'h0;
    end else begin
      state_r       <= state_next_s;
      last_served_r <= served_next_s;
      cnt_r         <= cnt_next_s;
      go_a_r        <= (state_next_s == ST_GRANT_A);
      go_b_r        <= (state_next_s == ST_GRANT_B);
      switch_pos_r  <= switch_next_s;
      busy_r        <= (state_next_s == ST_GRANT_A) || (state_next_s == ST_OCC_A) ||
                       (state_next_s == ST_GRANT_B) || (state_next_s == ST_OCC_B);
      fault_r       <= (state_next_s == ST_FAULT);
      state_code_r  <= state_next_s;
    end
  end

  assign bus.go_a       = go_a_r;
  assign bus.go_b       = go_b_r;
  assign bus.switch_pos = switch_pos_r;
  assign bus.busy       = busy_r;
  assign bus.fault      = fault_r;
  assign bus.state_code = state_code_r;

endmodule

// File: tb/tb_junction_arbiter.sv
// Directed bench for junction_arbiter with DEBOUNCE_CYCLES=2, SWITCH_SETTLE=3, TIMEOUT_CYCLES=20.
module tb_junction_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  junction_arbiter_if bus ();

  junction_arbiter #(
    .DEBOUNCE_CYCLES (2),
    .SWITCH_SETTLE   (3),
    .TIMEOUT_CYCLES  (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.s_req_a   = 1'b0;
    bus.s_req_b   = 1'b0;
    bus.s_entry_a = 1'b0;
    bus.s_entry_b = 1'b0;
    bus.s_exit    = 1'b0;
    bus.s_estop   = 1'b0;
    bus.fault_clr = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (bus.state_code !== 4'h0) $display("FAIL rst_code: got %h want 0", bus.state_code); else passed++;
    total++; if (bus.go_a !== 1'b0) $display("FAIL rst_go_a: got %b want 0", bus.go_a); else passed++;
    total++; if (bus.go_b !== 1'b0) $display("FAIL rst_go_b: got %b want 0", bus.go_b); else passed++;
    total++; if (bus.switch_pos !== 1'b0) $display("FAIL rst_switch: got %b want 0", bus.switch_pos); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", bus.fault); else passed++;
  endtask

  task automatic test_single_a;
    do_reset();
    bus.s_req_a = 1'b1;
    step(5);
    total++; if (bus.state_code !== 4'h1) $display("FAIL a_setup_code: got %h want 1", bus.state_code); else passed++;
    total++; if (bus.switch_pos !== 1'b0) $display("FAIL a_setup_switch: got %b want 0", bus.switch_pos); else passed++;
    total++; if (bus.go_a !== 1'b0) $display("FAIL a_setup_go: got %b want 0", bus.go_a); else passed++;
    step(2);
    total++; if (bus.go_a !== 1'b0) $display("FAIL a_settle_go_early: got %b want 0", bus.go_a); else passed++;
    step(1);
    total++; if (bus.state_code !== 4'h2) $display("FAIL a_grant_code: got %h want 2", bus.state_code); else passed++;
    total++; if (bus.go_a !== 1'b1) $display("FAIL a_grant_go: got %b want 1", bus.go_a); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL a_grant_busy: got %b want 1", bus.busy); else passed++;
    total++; if (bus.go_b !== 1'b0) $display("FAIL a_grant_go_b: got %b want 0", bus.go_b); else passed++;
    bus.s_req_a   = 1'b0;
    bus.s_entry_a = 1'b1;
    step(4);
    total++; if (bus.state_code !== 4'h2) $display("FAIL a_entry_early: got %h want 2", bus.state_code); else passed++;
    step(1);
    total++; if (bus.state_code !== 4'h3) $display("FAIL a_occ_code: got %h want 3", bus.state_code); else passed++;
    total++; if (bus.go_a !== 1'b0) $display("FAIL a_occ_go: got %b want 0", bus.go_a); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL a_occ_busy: got %b want 1", bus.busy); else passed++;
    bus.s_entry_a = 1'b0;
    bus.s_exit    = 1'b1;
    step(5);
    total++; if (bus.state_code !== 4'h0) $display("FAIL a_exit_code: got %h want 0", bus.state_code); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL a_exit_busy: got %b want 0", bus.busy); else passed++;
    bus.s_exit = 1'b0;
    step(6);
    // Having just served A, a tie must now go to B.
    bus.s_req_a = 1'b1;
    bus.s_req_b = 1'b1;
    step(5);
    total++; if (bus.state_code !== 4'h5) $display("FAIL a_then_tie_code: got %h want 5", bus.state_code); else passed++;
    total++; if (bus.switch_pos !== 1'b1) $display("FAIL a_then_tie_switch: got %b want 1", bus.switch_pos); else passed++;
  endtask

  task automatic test_simultaneous;
    do_reset();
    bus.s_req_a = 1'b1;
    bus.s_req_b = 1'b1;
    step(5);
    total++; if (bus.state_code !== 4'h1) $display("FAIL tie_first_code: got %h want 1", bus.state_code); else passed++;
    step(3);
    total++; if (bus.go_a !== 1'b1) $display("FAIL tie_go_a: got %b want 1", bus.go_a); else passed++;
    total++; if (bus.go_b !== 1'b0) $display("FAIL tie_go_b: got %b want 0", bus.go_b); else passed++;
    bus.s_req_a   = 1'b0;
    bus.s_entry_a = 1'b1;
    step(5);
    total++; if (bus.state_code !== 4'h3) $display("FAIL tie_occ_code: got %h want 3", bus.state_code); else passed++;
    bus.s_entry_a = 1'b0;
    bus.s_exit    = 1'b1;
    step(5);
    total++; if (bus.state_code !== 4'h0) $display("FAIL tie_exit_code: got %h want 0", bus.state_code); else passed++;
    step(1);
    total++; if (bus.state_code !== 4'h5) $display("FAIL tie_setup_b_code: got %h want 5", bus.state_code); else passed++;
    total++; if (bus.switch_pos !== 1'b1) $display("FAIL tie_setup_b_switch: got %b want 1", bus.switch_pos); else passed++;
    bus.s_exit = 1'b0;
    step(2);
    total++; if (bus.go_b !== 1'b0) $display("FAIL tie_go_b_early: got %b want 0", bus.go_b); else passed++;
    step(1);
    total++; if (bus.state_code !== 4'h6) $display("FAIL tie_grant_b_code: got %h want 6", bus.state_code); else passed++;
    total++; if (bus.go_b !== 1'b1) $display("FAIL tie_grant_b_go: got %b want 1", bus.go_b); else passed++;
  endtask

  task automatic test_glitch;
    do_reset();
    bus.s_req_b = 1'b1;
    step(1);
    bus.s_req_b = 1'b0;
    step(8);
    total++; if (bus.state_code !== 4'h0) $display("FAIL glitch_code: got %h want 0", bus.state_code); else passed++;
    total++; if (bus.switch_pos !== 1'b0) $display("FAIL glitch_switch: got %b want 0", bus.switch_pos); else passed++;
    bus.s_req_b = 1'b1;
    step(4);
    bus.s_req_b = 1'b0;
    step(1);
    total++; if (bus.state_code !== 4'h5) $display("FAIL pulse4_code: got %h want 5", bus.state_code); else passed++;
    total++; if (bus.switch_pos !== 1'b1) $display("FAIL pulse4_switch: got %b want 1", bus.switch_pos); else passed++;
  endtask

  task automatic test_wrong_entry;
    do_reset();
    bus.s_req_a = 1'b1;
    step(8);
    total++; if (bus.state_code !== 4'h2) $display("FAIL wrong_pre_code: got %h want 2", bus.state_code); else passed++;
    bus.s_req_a   = 1'b0;
    bus.s_entry_b = 1'b1;
    step(5);
    total++; if (bus.state_code !== 4'hF) $display("FAIL wrong_code: got %h want f", bus.state_code); else passed++;
    total++; if (bus.go_a !== 1'b0) $display("FAIL wrong_go_a: got %b want 0", bus.go_a); else passed++;
    total++; if (bus.fault !== 1'b1) $display("FAIL wrong_fault: got %b want 1", bus.fault); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL wrong_busy: got %b want 0", bus.busy); else passed++;
    bus.s_entry_b = 1'b0;
    step(6);
    total++; if (bus.state_code !== 4'hF) $display("FAIL wrong_sticky: got %h want f", bus.state_code); else passed++;
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
    total++; if (bus.state_code !== 4'h0) $display("FAIL wrong_clr_code: got %h want 0", bus.state_code); else passed++;
    total++; if (bus.fault !== 1'b0) $display("FAIL wrong_clr_fault: got %b want 0", bus.fault); else passed++;
  endtask

  task automatic test_estop;
    do_reset();
    bus.s_req_b = 1'b1;
    step(8);
    total++; if (bus.go_b !== 1'b1) $display("FAIL estop_pre_go_b: got %b want 1", bus.go_b); else passed++;
    bus.s_req_b   = 1'b0;
    bus.s_entry_b = 1'b1;
    step(5);
    total++; if (bus.state_code !== 4'h7) $display("FAIL estop_occ_b: got %h want 7", bus.state_code); else passed++;
    bus.s_entry_b = 1'b0;
    bus.s_estop   = 1'b1;
    step(4);
    total++; if (bus.state_code !== 4'h7) $display("FAIL estop_early: got %h want 7", bus.state_code); else passed++;
    step(1);
    total++; if (bus.state_code !== 4'hF) $display("FAIL estop_code: got %h want f", bus.state_code); else passed++;
    total++; if (bus.fault !== 1'b1) $display("FAIL estop_fault: got %b want 1", bus.fault); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL estop_busy: got %b want 0", bus.busy); else passed++;
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
    total++; if (bus.state_code !== 4'hF) $display("FAIL estop_clr_ignored: got %h want f", bus.state_code); else passed++;
    bus.s_estop = 1'b0;
    step(5);
    total++; if (bus.state_code !== 4'hF) $display("FAIL estop_sticky: got %h want f", bus.state_code); else passed++;
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
    total++; if (bus.state_code !== 4'h0) $display("FAIL estop_clr_code: got %h want 0", bus.state_code); else passed++;
  endtask

  task automatic test_async_reset;
    do_reset();
    bus.s_req_a = 1'b1;
    step(8);
    total++; if (bus.go_a !== 1'b1) $display("FAIL arst_pre_go: got %b want 1", bus.go_a); else passed++;
    rst_n = 1'b0;
    #2;
    total++; if (bus.go_a !== 1'b0) $display("FAIL arst_go: got %b want 0", bus.go_a); else passed++;
    total++; if (bus.state_code !== 4'h0) $display("FAIL arst_code: got %h want 0", bus.state_code); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", bus.busy); else passed++;
    clear_inputs();
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

`ifdef JUNCTION_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    bus.s_req_a = 1'b1;
    step(8);
    total++; if (bus.state_code !== 4'h2) $display("FAIL to_grant_code: got %h want 2", bus.state_code); else passed++;
    bus.s_req_b = 1'b1;
    step(19);
    total++; if (bus.go_a !== 1'b1) $display("FAIL to_early_go: got %b want 1", bus.go_a); else passed++;
    step(1);
    total++; if (bus.state_code !== 4'h0) $display("FAIL to_idle_code: got %h want 0", bus.state_code); else passed++;
    total++; if (bus.go_a !== 1'b0) $display("FAIL to_idle_go: got %b want 0", bus.go_a); else passed++;
    step(1);
    total++; if (bus.state_code !== 4'h5) $display("FAIL to_next_b: got %h want 5", bus.state_code); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_a();
    test_simultaneous();
    test_glitch();
    test_wrong_entry();
    test_estop();
    test_async_reset();
`ifdef JUNCTION_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
